trap_filter_sequencer: RTL
==========================

// Module: trap_filter_sequencer
// PURPOSE
//  Event sequencer for the trapezoidal-filter chain. Gates/clears the stage-2 integrator,
//  detects a trigger on the trapezoid output, times rise and flat-top, captures one energy
//  sample per event, hands it downstream via valid/ready, then enforces a dead time.
// PARAMETERS
//  DW   22  width of signed trapezoid sample TRAP_IN / ENERGY_OUT
//  CW   16  width of rise/flat/dead counters and config fields
//  EW   16  width of EVENT_CNT
// PORTS
//  SYS_CLK       in   1    system clock, all logic on rising edge
//  RESET_N       in   1    asynchronous active-low reset
//  CFG_ENABLE    in   1    1 = run sequencer; 0 = force IDLE
//  CFG_THRESH    in   DW   signed trigger threshold
//  CFG_RISE      in   CW   rise time in valid samples (0 treated as 1)
//  CFG_FLAT      in   CW   flat-top length in valid samples (0 treated as 1)
//  CFG_DEAD      in   CW   dead time in valid samples after an event (0 = none)
//  SAMPLE_VALID  in   1    new sample present on TRAP_IN this cycle
//  TRAP_IN       in   DW   signed trapezoid output of the filter chain
//  ACC_EN        out  1    integrator update enable = SAMPLE_VALID & (state!=IDLE)
//  ACC_CLR       out  1    one-cycle integrator clear pulse
//  ENERGY_OUT    out  DW   captured energy, stable while ENERGY_VALID
//  ENERGY_VALID  out  1    energy available
//  ENERGY_READY  in   1    downstream accepts energy
//  BUSY          out  1    state not IDLE/ARMED
//  PILEUP        out  1    one-cycle pulse on rejected event (PILEUP_REJECT_EN only)
//  EVENT_CNT     out  EW   accepted-event counter, wraps at 2^EW-1 -> 0
// BEHAVIOUR
//  Reset: state=IDLE; ACC_EN, ACC_CLR, ENERGY_VALID, BUSY, PILEUP = 0; ENERGY_OUT=0; EVENT_CNT=0.
//  All counters advance only on cycles with SAMPLE_VALID=1.
//  IDLE : CFG_ENABLE=1 -> ACC_CLR=1 for exactly one cycle, go ARMED next cycle.
//  ARMED: SAMPLE_VALID & TRAP_IN > CFG_THRESH (signed, strict) -> RISE, cnt=1.
//  RISE : cnt==max(CFG_RISE,1) on valid sample -> FLAT, cnt=1.
//  FLAT : at cnt==(max(CFG_FLAT,1)+1)>>1 capture TRAP_IN into ENERGY_OUT;
//         cnt==max(CFG_FLAT,1) -> OUT (capture and exit may coincide when FLAT<=2).
//  OUT  : ENERGY_VALID=1 from entry; transfer on ENERGY_VALID&ENERGY_READY; that cycle
//         EVENT_CNT+=1, next cycle ENERGY_VALID=0 -> DEAD (or ARMED if CFG_DEAD==0).
//         READY high on the entry cycle completes in that cycle (1-cycle VALID pulse).
//         Triggers while in OUT are ignored (no queueing).
//  DEAD : cnt==CFG_DEAD on valid sample -> ARMED. Threshold ignored.
//  Integrator keeps running (ACC_EN) in all states except IDLE; ACC_CLR only on IDLE exit.
//  CFG_ENABLE=0 in any state -> IDLE next cycle; pending ENERGY_VALID dropped, EVENT_CNT
//  not incremented, ENERGY_OUT retains last value. Config fields sampled live; changes
//  mid-event take effect at next comparison.
//  Reset mid-operation: asynchronous return to reset values above, regardless of state.
// CONFIGURATION
//  PILEUP_REJECT_EN defined: in FLAT, a rising crossing of TRAP_IN above CFG_THRESH
//   (previous valid sample <= thresh, current > thresh) -> PILEUP pulse 1 cycle, energy
//   discarded (no OUT, no EVENT_CNT change), go DEAD. Crossing on same sample as FLAT exit
//   also rejects. Previous-sample register cleared on RESET_N and in IDLE.
//  Not defined: PILEUP tied 0, no crossing register, every event reaches OUT.
// TESTING
//  1 reset then CFG_ENABLE 0->1 -> ACC_CLR exactly one cycle, state ARMED, ACC_EN follows VALID.
//  2 THRESH=100, RISE=4, FLAT=4, DEAD=3, step TRAP_IN to 500 every cycle, READY=1 ->
//    ENERGY_OUT=500, ENERGY_VALID 1 cycle, 9 valid samples after trigger, EVENT_CNT=1.
//  3 same as 2 with READY=0 for 10 cycles -> ENERGY_VALID/ENERGY_OUT held stable 10+ cycles,
//    extra triggers ignored, EVENT_CNT increments once on READY.
//  4 SAMPLE_VALID toggled 1/0 -> all count durations doubled in cycles, not in samples.
//  5 CFG_ENABLE dropped while ENERGY_VALID=1 -> IDLE next cycle, VALID=0, EVENT_CNT unchanged.
//  6 PILEUP_REJECT_EN: TRAP_IN drops to 50 then 300 during FLAT -> PILEUP pulse, no VALID,
//    state DEAD; without macro same stimulus -> normal OUT, PILEUP stays 0.

Source files
------------

// File: rtl/trap_filter_sequencer.sv
// Event sequencer for the trapezoidal-filter chain: arm, trigger, rise, flat-top capture, hand-off, dead time.
// Optional build macro PILEUP_REJECT_EN rejects events whose flat-top sees a fresh threshold crossing.
module trap_filter_sequencer #(
   parameter int DW = 22,
   parameter int CW = 16,
   parameter int EW = 16
) (
   input  logic          SYS_CLK,
   input  logic          RESET_N,
   input  logic          CFG_ENABLE,
   input  logic [DW-1:0] CFG_THRESH,
   input  logic [CW-1:0] CFG_RISE,
   input  logic [CW-1:0] CFG_FLAT,
   input  logic [CW-1:0] CFG_DEAD,
   input  logic          SAMPLE_VALID,
   input  logic [DW-1:0] TRAP_IN,
   output logic          ACC_EN,
   output logic          ACC_CLR,
   output logic [DW-1:0] ENERGY_OUT,
   output logic          ENERGY_VALID,
   input  logic          ENERGY_READY,
   output logic          BUSY,
   output logic          PILEUP,
   output logic [EW-1:0] EVENT_CNT,
   output logic [2:0]    DBG_STATE
);

   // DBG_STATE encoding: 0 IDLE, 1 ARMED, 2 RISE, 3 FLAT, 4 OUT, 5 DEAD.
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARMED = 3'd1,
      S_RISE  = 3'd2,
      S_FLAT  = 3'd3,
      S_OUT   = 3'd4,
      S_DEAD  = 3'd5
   } state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [DW-1:0] energy_q;
   logic          valid_q;
   logic          busy_q;
   logic          clr_q;
   logic [EW-1:0] evt_q;

   logic [CW-1:0] rise_eff;
   logic [CW-1:0] flat_eff;
   logic [CW-1:0] cap_pt;
   logic [CW-1:0] cnt_d;
   logic          above;

   assign rise_eff = (CFG_RISE == '0) ? CW'(1) : CFG_RISE;
   assign flat_eff = (CFG_FLAT == '0) ? CW'(1) : CFG_FLAT;
   // (flat+1)>>1 without a carry bit: floor(flat/2) plus the odd bit.
   assign cap_pt   = {1'b0, flat_eff[CW-1:1]} + CW'(flat_eff[0]);
   assign cnt_d    = cnt_q + CW'(1);
   assign above    = $signed(TRAP_IN) > $signed(CFG_THRESH);

`ifdef PILEUP_REJECT_EN
   logic          pileup_q;
   logic [DW-1:0] prev_q;
   logic          crossing;
   assign crossing = above && ($signed(prev_q) <= $signed(CFG_THRESH));
   assign PILEUP   = pileup_q;
`else
   assign PILEUP   = 1'b0;
`endif

   // Handshake: ENERGY_VALID rises on OUT entry and holds ENERGY_OUT stable until a cycle
   // with ENERGY_READY high; the transfer completes on that edge and VALID drops next cycle.
   assign ACC_EN       = SAMPLE_VALID & (state_q != S_IDLE);
   assign ACC_CLR      = clr_q;
   assign ENERGY_OUT   = energy_q;
   assign ENERGY_VALID = valid_q;
   assign BUSY         = busy_q;
   assign EVENT_CNT    = evt_q;
   assign DBG_STATE    = state_q;

   always_ff @(posedge SYS_CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         energy_q <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         clr_q    <= 1'b0;
         evt_q    <= '0;
`ifdef PILEUP_REJECT_EN
         pileup_q <= 1'b0;
         prev_q   <= '0;
`endif
      end else begin
         clr_q <= 1'b0;
`ifdef PILEUP_REJECT_EN
         pileup_q <= 1'b0;
         if (!CFG_ENABLE || state_q == S_IDLE) prev_q <= '0;
         else if (SAMPLE_VALID)                 prev_q <= TRAP_IN;
`endif
         if (!CFG_ENABLE) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  state_q <= S_ARMED;
                  clr_q   <= 1'b1;
               end
               S_ARMED: if (SAMPLE_VALID && above) begin
                  state_q <= S_RISE;
                  busy_q  <= 1'b1;
                  cnt_q   <= CW'(1);
               end
               S_RISE: if (SAMPLE_VALID) begin
                  if (cnt_q >= rise_eff) begin
                     state_q <= S_FLAT;
                     cnt_q   <= CW'(1);
                  end else begin
                     cnt_q <= cnt_d;
                  end
               end
               S_FLAT: if (SAMPLE_VALID) begin
`ifdef PILEUP_REJECT_EN
                  if (crossing) begin
                     pileup_q <= 1'b1;
                     state_q  <= S_DEAD;
                     cnt_q    <= CW'(1);
                  end else
`endif
                  begin
                     if (cnt_q == cap_pt) energy_q <= TRAP_IN;
                     if (cnt_q >= flat_eff) begin
                        state_q <= S_OUT;
                        valid_q <= 1'b1;
                     end else begin
                        cnt_q <= cnt_d;
                     end
                  end
               end
               S_OUT: if (ENERGY_READY) begin
                  valid_q <= 1'b0;
                  evt_q   <= evt_q + EW'(1);
                  if (CFG_DEAD == '0) begin
                     state_q <= S_ARMED;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= S_DEAD;
                     cnt_q   <= CW'(1);
                  end
               end
               S_DEAD: if (SAMPLE_VALID) begin
                  if (cnt_q >= CFG_DEAD) begin
                     state_q <= S_ARMED;
                     busy_q  <= 1'b0;
                  end else begin
                     cnt_q <= cnt_d;
                  end
               end
               default: begin
                  state_q <= S_IDLE;
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
